// File: rtl/prog_mem_pkg.sv
// Shared types and default widths for the program-memory arbiter.
package prog_mem_pkg;

   localparam int DEF_AW = 15;
   localparam int DEF_DW = 16;

   typedef enum logic {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_FETCH = 2'd1,
      OWN_LOAD  = 2'd2
   } owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter; bit 0 = fetch, bit 1 = loader.
// fetch_en_i masks the fetch request so the loader owns memory during boot.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset,
   input  logic       fetch_en_i,
   input  logic [1:0] req_i,
   output logic [1:0] grant_o
);

   logic       last_load_q;
   logic       last_load_d;
   logic [1:0] req_eff;

   always_comb begin
      req_eff     = {req_i[1], req_i[0] & fetch_en_i};
      grant_o     = 2'b00;
      last_load_d = last_load_q;
      case (req_eff)
         2'b01:   grant_o = 2'b01;
         2'b10:   grant_o = 2'b10;
         2'b11:   grant_o = last_load_q ? 2'b01 : 2'b10;
         default: grant_o = 2'b00;
      endcase
      // Idle cycles leave the history alone so the next tie still alternates.
      if (grant_o != 2'b00) last_load_d = grant_o[1];
   end

   // Reset as "loader last" so the CPU wins the first tie.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) last_load_q <= 1'b1;
      else       last_load_q <= last_load_d;
   end

endmodule

// File: rtl/prog_mem_arbiter.sv
// Shares the single-port program memory between CPU fetch and the loader,
// holding the CPU in BOOT until the loader reports the image is in place.
module prog_mem_arbiter
   import prog_mem_pkg::*;
#(
   parameter int AW        = DEF_AW,
   parameter int DW        = DEF_DW,
   parameter bit BOOT_HOLD = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          fetch_req,
   input  logic [AW-1:0] fetch_addr,
   output logic          cpu_hold,
   output logic          fetch_valid,
   output logic [DW-1:0] fetch_data,
   input  logic          ld_req,
   input  logic          ld_we,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_wdata,
   output logic          ld_ack,
   output logic          ld_rdata_valid,
   output logic [DW-1:0] ld_rdata,
   input  logic          ld_done,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_q,
   output state_e        dbg_state_o
);

   state_e        state_q, state_d;
   owner_e        rd_owner_q, rd_owner_d;
   logic [AW-1:0] mem_addr_q;
   logic [1:0]    grant;
   logic          fetch_grant;
   logic          ld_grant;

   rr_arb2 u_arb (
      .clk        (clk),
      .reset      (reset),
      .fetch_en_i (state_q == ST_RUN),
      .req_i      ({ld_req, fetch_req}),
      .grant_o    (grant)
   );

   assign fetch_grant = grant[0];
   assign ld_grant    = grant[1];

   always_comb begin
      state_d    = state_q;
      rd_owner_d = OWN_NONE;
      mem_addr   = mem_addr_q;
      if (state_q == ST_BOOT && ld_done) state_d = ST_RUN;
      if (fetch_grant) begin
         mem_addr   = fetch_addr;
         rd_owner_d = OWN_FETCH;
      end else if (ld_grant) begin
         mem_addr   = ld_addr;
         rd_owner_d = ld_we ? OWN_NONE : OWN_LOAD;
      end
   end

   assign cpu_hold       = (state_q == ST_BOOT) | (fetch_req & ~fetch_grant);
   assign ld_ack         = ld_grant;
   assign mem_we         = ld_grant & ld_we;
   assign mem_wdata      = ld_wdata;
   assign fetch_valid    = (rd_owner_q == OWN_FETCH);
   assign ld_rdata_valid = (rd_owner_q == OWN_LOAD);
   assign fetch_data     = mem_q;
   assign ld_rdata       = mem_q;
   assign dbg_state_o    = state_q;

   // Reset clears rd_owner, so a read in flight at reset never returns valid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= BOOT_HOLD ? ST_BOOT : ST_RUN;
         rd_owner_q <= OWN_NONE;
         mem_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         rd_owner_q <= rd_owner_d;
         mem_addr_q <= mem_addr;
      end
   end

endmodule

// File: tb/tb_prog_mem_arbiter.sv
// Directed bench: one BOOT_HOLD=1 instance and one BOOT_HOLD=0 instance,
// each with its own write-first, 1-cycle-latency memory model.
module tb_prog_mem_arbiter;
  import prog_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req, fetch_req1;
  logic [14:0] fetch_addr;
  logic        ld_req, ld_we, ld_done;
  logic [14:0] ld_addr;
  logic [15:0] ld_wdata;

  logic        cpu_hold0, fetch_valid0, ld_ack0, ld_rdata_valid0, mem_we0;
  logic [15:0] fetch_data0, ld_rdata0, mem_wdata0, mem_q0;
  logic [14:0] mem_addr0;
  state_e      dbg0;

  logic        cpu_hold1, fetch_valid1, ld_ack1, ld_rdata_valid1, mem_we1;
  logic [15:0] fetch_data1, ld_rdata1, mem_wdata1, mem_q1;
  logic [14:0] mem_addr1;
  state_e      dbg1;

  logic [15:0] mem0 [0:255];
  logic [15:0] mem1 [0:255];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prog_mem_arbiter #(.AW(15), .DW(16), .BOOT_HOLD(1'b1)) dut0 (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .cpu_hold(cpu_hold0),
    .fetch_valid(fetch_valid0), .fetch_data(fetch_data0),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_ack(ld_ack0), .ld_rdata_valid(ld_rdata_valid0), .ld_rdata(ld_rdata0),
    .ld_done(ld_done), .mem_addr(mem_addr0), .mem_we(mem_we0),
    .mem_wdata(mem_wdata0), .mem_q(mem_q0), .dbg_state_o(dbg0)
  );

  prog_mem_arbiter #(.AW(15), .DW(16), .BOOT_HOLD(1'b0)) dut1 (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req1), .fetch_addr(fetch_addr), .cpu_hold(cpu_hold1),
    .fetch_valid(fetch_valid1), .fetch_data(fetch_data1),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_ack(ld_ack1), .ld_rdata_valid(ld_rdata_valid1), .ld_rdata(ld_rdata1),
    .ld_done(ld_done), .mem_addr(mem_addr1), .mem_we(mem_we1),
    .mem_wdata(mem_wdata1), .mem_q(mem_q1), .dbg_state_o(dbg1)
  );

  always @(posedge clk) begin
    if (mem_we0) mem0[mem_addr0[7:0]] <= mem_wdata0;
    mem_q0 <= mem_we0 ? mem_wdata0 : mem0[mem_addr0[7:0]];
    if (mem_we1) mem1[mem_addr1[7:0]] <= mem_wdata1;
    mem_q1 <= mem_we1 ? mem_wdata1 : mem1[mem_addr1[7:0]];
  end

  task automatic drive_idle();
    fetch_req  = 1'b0;
    fetch_req1 = 1'b0;
    fetch_addr = '0;
    ld_req     = 1'b0;
    ld_we      = 1'b0;
    ld_addr    = '0;
    ld_wdata   = '0;
    ld_done    = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (dbg0 !== ST_BOOT) begin errors++; $display("FAIL reset_state0 got %0d exp %0d", dbg0, ST_BOOT); end
    checks++; if (cpu_hold0 !== 1'b1) begin errors++; $display("FAIL reset_cpu_hold0 got %b exp 1", cpu_hold0); end
    checks++; if (fetch_valid0 !== 1'b0 || ld_rdata_valid0 !== 1'b0) begin errors++; $display("FAIL reset_valids0 got %b%b exp 00", fetch_valid0, ld_rdata_valid0); end
    checks++; if (ld_ack0 !== 1'b0 || mem_we0 !== 1'b0) begin errors++; $display("FAIL reset_ack_we0 got %b%b exp 00", ld_ack0, mem_we0); end
    checks++; if (mem_addr0 !== 15'h0) begin errors++; $display("FAIL reset_mem_addr0 got %h exp 0000", mem_addr0); end
    checks++; if (dbg1 !== ST_RUN) begin errors++; $display("FAIL reset_state1 got %0d exp %0d", dbg1, ST_RUN); end
  endtask

  task automatic test_boot_load();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      fetch_req  = 1'b1;
      fetch_addr = 15'h0;
      ld_req     = 1'b1;
      ld_we      = 1'b1;
      ld_addr    = 15'(i);
      ld_wdata   = 16'hA001 + 16'(i);
      #1;
      checks++; if (cpu_hold0 !== 1'b1) begin errors++; $display("FAIL boot_cpu_hold[%0d] got %b exp 1", i, cpu_hold0); end
      checks++; if (ld_ack0 !== 1'b1 || mem_we0 !== 1'b1) begin errors++; $display("FAIL boot_ack_we[%0d] got %b%b exp 11", i, ld_ack0, mem_we0); end
      checks++; if (mem_addr0 !== 15'(i) || mem_wdata0 !== 16'hA001 + 16'(i)) begin errors++; $display("FAIL boot_mem_bus[%0d] got %h/%h exp %h/%h", i, mem_addr0, mem_wdata0, 15'(i), 16'hA001 + 16'(i)); end
      @(posedge clk); #1;
      checks++; if (fetch_valid0 !== 1'b0 || ld_rdata_valid0 !== 1'b0) begin errors++; $display("FAIL boot_no_valid[%0d] got %b%b exp 00", i, fetch_valid0, ld_rdata_valid0); end
    end
  endtask

  task automatic test_release();
    @(negedge clk);
    drive_idle();
    ld_done = 1'b1;
    #1;
    checks++; if (dbg0 !== ST_BOOT || cpu_hold0 !== 1'b1) begin errors++; $display("FAIL done_same_cycle got state %0d hold %b exp BOOT/1", dbg0, cpu_hold0); end
    @(posedge clk); #1;
    checks++; if (dbg0 !== ST_RUN) begin errors++; $display("FAIL done_to_run got %0d exp %0d", dbg0, ST_RUN); end
    @(negedge clk);
    ld_done    = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 15'h0002;
    #1;
    checks++; if (cpu_hold0 !== 1'b0 || mem_addr0 !== 15'h0002) begin errors++; $display("FAIL release_fetch_grant got hold %b addr %h exp 0/0002", cpu_hold0, mem_addr0); end
    @(posedge clk); #1;
    checks++; if (fetch_valid0 !== 1'b1 || fetch_data0 !== 16'hA003) begin errors++; $display("FAIL release_fetch_data got %b/%h exp 1/a003", fetch_valid0, fetch_data0); end
  endtask

  task automatic test_loader_read();
    @(negedge clk);
    drive_idle();
    ld_req  = 1'b1;
    ld_addr = 15'h0001;
    #1;
    checks++; if (ld_ack0 !== 1'b1 || mem_we0 !== 1'b0) begin errors++; $display("FAIL ld_read_grant got ack %b we %b exp 1/0", ld_ack0, mem_we0); end
    @(posedge clk); #1;
    checks++; if (ld_rdata_valid0 !== 1'b1 || fetch_valid0 !== 1'b0 || ld_rdata0 !== 16'hA002) begin errors++; $display("FAIL ld_read_data got %b%b/%h exp 10/a002", ld_rdata_valid0, fetch_valid0, ld_rdata0); end
  endtask

  task automatic test_contention();
    logic exp_f;
    @(negedge clk);
    drive_idle();
    fetch_req  = 1'b1;
    fetch_addr = 15'h0002;
    ld_req     = 1'b1;
    ld_addr    = 15'h0001;
    for (int i = 0; i < 6; i++) begin
      if (i != 0) @(negedge clk);
      exp_f = (i % 2 == 0);
      #1;
      checks++; if (cpu_hold0 !== !exp_f || ld_ack0 !== !exp_f) begin errors++; $display("FAIL contend_grant[%0d] got hold %b ack %b exp %b/%b", i, cpu_hold0, ld_ack0, !exp_f, !exp_f); end
      checks++; if (mem_addr0 !== (exp_f ? 15'h0002 : 15'h0001)) begin errors++; $display("FAIL contend_addr[%0d] got %h exp %h", i, mem_addr0, exp_f ? 15'h0002 : 15'h0001); end
      @(posedge clk); #1;
      checks++; if (fetch_valid0 !== exp_f || ld_rdata_valid0 !== !exp_f) begin errors++; $display("FAIL contend_valid[%0d] got %b%b exp %b%b", i, fetch_valid0, ld_rdata_valid0, exp_f, !exp_f); end
      checks++; if (fetch_data0 !== (exp_f ? 16'hA003 : 16'hA002)) begin errors++; $display("FAIL contend_data[%0d] got %h exp %h", i, fetch_data0, exp_f ? 16'hA003 : 16'hA002); end
    end
  endtask

  task automatic test_write_then_read();
    @(negedge clk);
    drive_idle();
    ld_req   = 1'b1;
    ld_we    = 1'b1;
    ld_addr  = 15'h0005;
    ld_wdata = 16'h1234;
    #1;
    checks++; if (mem_we0 !== 1'b1 || mem_addr0 !== 15'h0005) begin errors++; $display("FAIL wr_grant got we %b addr %h exp 1/0005", mem_we0, mem_addr0); end
    @(negedge clk);
    drive_idle();
    fetch_req  = 1'b1;
    fetch_addr = 15'h0005;
    #1;
    checks++; if (ld_rdata_valid0 !== 1'b0 || cpu_hold0 !== 1'b0) begin errors++; $display("FAIL wr_no_return got rvalid %b hold %b exp 0/0", ld_rdata_valid0, cpu_hold0); end
    @(posedge clk); #1;
    checks++; if (fetch_valid0 !== 1'b1 || fetch_data0 !== 16'h1234) begin errors++; $display("FAIL wr_then_rd got %b/%h exp 1/1234", fetch_valid0, fetch_data0); end
  endtask

  task automatic test_done_in_run();
    @(negedge clk);
    drive_idle();
    ld_done = 1'b1;
    #1;
    checks++; if (mem_addr0 !== 15'h0005) begin errors++; $display("FAIL idle_addr_hold got %h exp 0005", mem_addr0); end
    @(posedge clk); #1;
    checks++; if (dbg0 !== ST_RUN || fetch_valid0 !== 1'b0) begin errors++; $display("FAIL done_in_run got state %0d valid %b exp RUN/0", dbg0, fetch_valid0); end
    @(negedge clk);
    ld_done = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    drive_idle();
    fetch_req  = 1'b1;
    fetch_addr = 15'h0000;
    #1;
    checks++; if (cpu_hold0 !== 1'b0) begin errors++; $display("FAIL midrst_grant got hold %b exp 0", cpu_hold0); end
    #2;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (fetch_valid0 !== 1'b0 || dbg0 !== ST_BOOT || cpu_hold0 !== 1'b1) begin errors++; $display("FAIL midrst_in_reset got valid %b state %0d hold %b exp 0/BOOT/1", fetch_valid0, dbg0, cpu_hold0); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (fetch_valid0 !== 1'b0 || cpu_hold0 !== 1'b1) begin errors++; $display("FAIL midrst_after got valid %b hold %b exp 0/1", fetch_valid0, cpu_hold0); end
  endtask

  task automatic test_no_boot_hold();
    @(negedge clk);
    drive_idle();
    fetch_req1 = 1'b1;
    fetch_addr = 15'h0002;
    #1;
    checks++; if (cpu_hold1 !== 1'b0 || dbg1 !== ST_RUN) begin errors++; $display("FAIL nohold_grant got hold %b state %0d exp 0/RUN", cpu_hold1, dbg1); end
    checks++; if (cpu_hold0 !== 1'b1) begin errors++; $display("FAIL hold_boot_idle got %b exp 1", cpu_hold0); end
    @(posedge clk); #1;
    checks++; if (fetch_valid1 !== 1'b1 || fetch_data1 !== 16'hA003) begin errors++; $display("FAIL nohold_data got %b/%h exp 1/a003", fetch_valid1, fetch_data1); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_boot_load();
    test_release();
    test_loader_read();
    test_contention();
    test_write_then_read();
    test_done_in_run();
    test_reset_mid_read();
    test_no_boot_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
